counter_ctrl: RTL and testbench

- Front-end control stage that sits directly upstream of the 4-bit up/down counter.
- Turns raw board buttons and switches into the counter's `D`, `load`, `en` and `addsub` controls.
- Synchronises and debounces the buttons, detects presses, and runs a small FSM for single-step, load and free-running (auto-tick) modes.

---
 rtl/counter_pkg.sv | 14 +
 rtl/debounce.sv | 56 +++++
 rtl/counter_ctrl.sv | 152 +++++++++++++++
 tb/tb_counter_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the counter front-end control stage.
package counter_pkg;

  // Counter data width; must match the downstream up/down counter.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    LOAD = 2'd2,
    RUN  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchroniser, stability debouncer and a
// one-cycle pulse on each debounced 0->1 transition.
module debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]        sync;
  logic              level;
  logic              level_q;
  logic [DCNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Flip the level only after DEB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync[1] != level) begin
      if (cnt == DCNT_W'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + DCNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulse on a debounced rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Front-end control for the 4-bit up/down counter: conditions the board
// buttons and switches and drives D/load/en/addsub through a small FSM
// with single-step, load and free-running modes.
// Optional macro LIMIT_STOP_EN: stop RUN instead of wrapping at F (up) or 0 (down).
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TICK_DIV   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_run,
  input  logic [CNT_W-1:0] sw_d,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] D,
  output logic             load,
  output logic             en,
  output logic             addsub,
  output logic             running
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic p_load;
  logic p_up;
  logic p_down;
  logic p_run;

  logic [CNT_W-1:0]  sw_s1;
  logic [CNT_W-1:0]  sw_s2;
  ctrl_state_t       state;
  logic              run_ret;
  logic [TICK_W-1:0] tick;
  logic              tick_wrap;
  logic              at_limit;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (.clk(clk), .reset(reset), .raw(btn_load), .press(p_load));
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up   (.clk(clk), .reset(reset), .raw(btn_up),   .press(p_up));
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (.clk(clk), .reset(reset), .raw(btn_down), .press(p_down));
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run  (.clk(clk), .reset(reset), .raw(btn_run),  .press(p_run));

  assign tick_wrap = (tick == TICK_W'(TICK_DIV - 1));

`ifdef LIMIT_STOP_EN
  // The next step in the current direction would wrap the counter.
  assign at_limit = addsub ? (count == '1) : (count == '0);
`else
  logic unused_count;
  assign unused_count = ^count;
  assign at_limit     = 1'b0;
`endif

  // Synchronise the switches and present them as the load value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      D     <= '0;
    end else begin
      sw_s1 <= sw_d;
      sw_s2 <= sw_s1;
      D     <= sw_s2;
    end
  end

  // Mode FSM; en/load are strobes that default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      run_ret <= 1'b0;
      tick    <= '0;
      en      <= 1'b0;
      load    <= 1'b0;
      addsub  <= 1'b1;
      running <= 1'b0;
    end else begin
      en   <= 1'b0;
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (p_load) begin
            state   <= LOAD;
            run_ret <= 1'b0;
            en      <= 1'b1;
            load    <= 1'b1;
          end else if (p_up) begin
            addsub <= 1'b1;
            state  <= STEP;
            en     <= 1'b1;
          end else if (p_down) begin
            addsub <= 1'b0;
            state  <= STEP;
            en     <= 1'b1;
          end else if (p_run) begin
            state   <= RUN;
            running <= 1'b1;
            tick    <= '0;
          end
        end
        STEP: begin
          state <= IDLE;
        end
        LOAD: begin
          if (run_ret) begin
            state   <= RUN;
            running <= 1'b1;
            tick    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (p_load) begin
            state   <= LOAD;
            run_ret <= 1'b1;
            running <= 1'b0;
            en      <= 1'b1;
            load    <= 1'b1;
          end else if (p_run) begin
            state   <= IDLE;
            running <= 1'b0;
          end else begin
            if (p_up) begin
              addsub <= 1'b1;
            end else if (p_down) begin
              addsub <= 1'b0;
            end
            if (tick_wrap) begin
              tick <= '0;
              if (at_limit) begin
                state   <= IDLE;
                running <= 1'b0;
              end else begin
                en <= 1'b1;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: table of single button presses, plus hand-written
// sequences for bouncing, RUN mode, simultaneous presses, reset and wrap.
module tb_counter_ctrl;

  localparam int BL = 0;
  localparam int BU = 1;
  localparam int BD = 2;
  localparam int BR = 3;

  typedef struct {
    int         cyc;
    logic       ld;
    logic       dir;
    logic [3:0] d;
  } ev_t;

  typedef struct {
    int         btn;
    int         hold;
    logic [3:0] sw;
    logic       ld;
    logic       dir;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_load;
  logic       btn_up;
  logic       btn_down;
  logic       btn_run;
  logic [3:0] sw_d;
  logic [3:0] count;
  logic [3:0] D;
  logic       load;
  logic       en;
  logic       addsub;
  logic       running;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] cnt_m;
  ev_t        exp_q[$];

  counter_ctrl #(.DEB_CYCLES(4), .TICK_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .btn_load(btn_load), .btn_up(btn_up), .btn_down(btn_down), .btn_run(btn_run),
    .sw_d(sw_d), .count(count),
    .D(D), .load(load), .en(en), .addsub(addsub), .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 4-bit counter stand-in, fed back on count.
  always @(posedge clk) begin
    if (reset) cnt_m <= 4'h0;
    else if (en) cnt_m <= load ? D : (addsub ? cnt_m + 4'd1 : cnt_m - 4'd1);
  end
  assign count = cnt_m;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      BL: btn_load = v;
      BU: btn_up   = v;
      BD: btn_down = v;
      default: btn_run = v;
    endcase
  endtask

  // Raise a button for 'hold' sampled cycles; n is the first sampling edge.
  task automatic press(input int b, input int hold, input bit has_ev, input logic ld,
                       input logic dir, input logic [3:0] d, output int n);
    n = cyc + 1;
    set_btn(b, 1'b1);
    if (has_ev) exp_q.push_back(ev_t'{n + 7, ld, dir, d});
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  // Scoreboard: every en/load strobe must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (en || load) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe at cycle %0d: en=%0b load=%0b, none expected", cyc, en, load);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_en", int'(en), 1);
          chk("strobe_load", int'(load), int'(e.ld));
          chk("strobe_dir", int'(addsub), int'(e.dir));
          if (e.ld) chk("load_d", int'(D), int'(e.d));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_strobe at cycle %0d: got none expected at cycle %0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t       tbl[7];
    int         n;
    int         e0;
    logic [8:0] pat;

    reset = 1'b1;
    btn_load = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_run = 1'b0;
    sw_d = 4'h0;

    tbl[0] = '{BL, 10, 4'hA, 1'b1, 1'b1, 4'hA};
    tbl[1] = '{BU,  6, 4'hA, 1'b0, 1'b1, 4'hB};
    tbl[2] = '{BD,  6, 4'hA, 1'b0, 1'b0, 4'hA};
    tbl[3] = '{BL,  8, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[4] = '{BD,  5, 4'h0, 1'b0, 1'b0, 4'hF};
    tbl[5] = '{BU,  4, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[6] = '{BL, 10, 4'hA, 1'b1, 1'b1, 4'hA};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Quiet after reset: outputs hold reset values.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset_idle", int'({D, load, en, addsub, running}), 8'h02);
    end

    // Single presses from IDLE.
    for (int i = 0; i < 7; i++) begin
      sw_d = tbl[i].sw;
      press(tbl[i].btn, tbl[i].hold, 1'b1, tbl[i].ld, tbl[i].dir, tbl[i].sw, n);
      wait_until(n + 25);
      chk($sformatf("vec%0d_cnt", i), int'(cnt_m), int'(tbl[i].cnt));
    end

    // Glitchy down button then a clean hold: one step down only.
    pat = 9'b101001000;
    for (int i = 8; i >= 0; i--) begin
      btn_down = pat[i];
      @(negedge clk);
    end
    press(BD, 6, 1'b1, 1'b0, 1'b0, 4'h0, n);
    wait_until(n + 25);
    chk("bounce_cnt", int'(cnt_m), 9);

    // RUN: tick every 8 cycles, direction change without a step, then stop.
    press(BR, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    e0 = n + 7;
    exp_q.push_back(ev_t'{e0 + 8,  1'b0, 1'b0, 4'h0});
    exp_q.push_back(ev_t'{e0 + 16, 1'b0, 1'b0, 4'h0});
    exp_q.push_back(ev_t'{e0 + 24, 1'b0, 1'b1, 4'h0});
    exp_q.push_back(ev_t'{e0 + 32, 1'b0, 1'b1, 4'h0});
    wait_until(e0 - 1);
    chk("run_not_yet", int'(running), 0);
    wait_until(e0);
    chk("run_entered", int'(running), 1);
    wait_until(e0 + 12);
    press(BU, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    wait_until(e0 + 21);
    chk("run_dir_up", int'(addsub), 1);
    wait_until(e0 + 28);
    press(BR, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    wait_until(e0 + 35);
    chk("run_still", int'(running), 1);
    wait_until(e0 + 36);
    chk("run_exit", int'(running), 0);
    wait_until(e0 + 50);
    chk("run_cnt", int'(cnt_m), 9);

    // Set direction down, then load and up together: only the load happens.
    press(BD, 6, 1'b1, 1'b0, 1'b0, 4'h0, n);
    wait_until(n + 25);
    chk("down_cnt", int'(cnt_m), 8);
    sw_d = 4'h5;
    n = cyc + 1;
    btn_load = 1'b1;
    btn_up   = 1'b1;
    exp_q.push_back(ev_t'{n + 7, 1'b1, 1'b0, 4'h5});
    repeat (8) @(negedge clk);
    btn_load = 1'b0;
    btn_up   = 1'b0;
    wait_until(n + 25);
    chk("prio_cnt", int'(cnt_m), 5);
    chk("prio_dir", int'(addsub), 0);

    // Reset in the middle of RUN with a button held across it.
    press(BR, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    e0 = n + 7;
    exp_q.push_back(ev_t'{e0 + 8, 1'b0, 1'b0, 4'h0});
    wait_until(e0 + 8);
    btn_up = 1'b1;
    wait_until(e0 + 10);
    reset = 1'b1;
    wait_until(e0 + 11);
    chk("reset_mid_run", int'({D, load, en, addsub, running}), 8'h02);
    reset = 1'b0;
    exp_q.push_back(ev_t'{e0 + 19, 1'b0, 1'b1, 4'h0});
    wait_until(e0 + 24);
    btn_up = 1'b0;
    wait_until(e0 + 40);
    chk("held_after_reset_cnt", int'(cnt_m), 1);

    // Load D and run upward through the top of the range.
    sw_d = 4'hD;
    press(BL, 8, 1'b1, 1'b1, 1'b1, 4'hD, n);
    wait_until(n + 25);
    chk("load_d_cnt", int'(cnt_m), 13);
    press(BR, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    e0 = n + 7;
    exp_q.push_back(ev_t'{e0 + 8,  1'b0, 1'b1, 4'h0});
    exp_q.push_back(ev_t'{e0 + 16, 1'b0, 1'b1, 4'h0});
    wait_until(e0 + 20);
    chk("top_cnt", int'(cnt_m), 15);
`ifdef LIMIT_STOP_EN
    wait_until(e0 + 23);
    chk("limit_running_before", int'(running), 1);
    wait_until(e0 + 24);
    chk("limit_running_after", int'(running), 0);
    wait_until(e0 + 40);
    chk("limit_cnt_held", int'(cnt_m), 15);
    chk("limit_stays_idle", int'(running), 0);
`else
    exp_q.push_back(ev_t'{e0 + 24, 1'b0, 1'b1, 4'h0});
    exp_q.push_back(ev_t'{e0 + 32, 1'b0, 1'b1, 4'h0});
    wait_until(e0 + 26);
    chk("wrap_cnt", int'(cnt_m), 0);
    chk("wrap_running", int'(running), 1);
    wait_until(e0 + 28);
    press(BR, 6, 1'b0, 1'b0, 1'b0, 4'h0, n);
    wait_until(e0 + 36);
    chk("wrap_exit", int'(running), 0);
    wait_until(e0 + 50);
    chk("wrap_cnt_after", int'(cnt_m), 1);
`endif

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
